// File: rtl/game_flow_ctrl.sv
// Game sequencing for a flappy-bird style game: ms prescaler, button debounce,
// IDLE/PLAY/DEAD flow, flap strobing and score/best keeping.
module game_flow_ctrl #(
  parameter int MS_DIV       = 100000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int DEAD_HOLD_MS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       bird_dead,
  input  logic       pipe_passed,
  output logic [1:0] state,
  output logic       tick_ms,
  output logic       up_pulse,
  output logic       bird_rst,
  output logic [9:0] score,
  output logic [9:0] best
);

  localparam int PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int DW = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;
  localparam int HW = $clog2(DEAD_HOLD_MS + 1);

  localparam logic [PW-1:0] PS_LAST   = PW'(MS_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(DEAD_HOLD_MS);
  localparam logic [9:0]    SCORE_MAX = 10'd999;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  logic [PW-1:0] ps_cnt_reg;
  logic          sync1_reg;
  logic          sync2_reg;
  logic          btn_db_reg;
  logic [DW-1:0] db_cnt_reg;
  logic          pending_reg;
  logic [HW-1:0] hold_cnt_reg;
  logic [1:0]    state_reg;
  logic [9:0]    score_reg;
  logic [9:0]    best_reg;
  logic          tick;
  logic          press;

  assign tick = (ps_cnt_reg == PS_LAST);

  // A press is the tick on which a rising level completes its debounce window.
  assign press = tick && sync2_reg && !btn_db_reg && (db_cnt_reg == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt_reg <= '0;
    end else if (tick) begin
      ps_cnt_reg <= '0;
    end else begin
      ps_cnt_reg <= ps_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_reg <= 1'b0;
      db_cnt_reg <= '0;
    end else if (tick) begin
      if (sync2_reg != btn_db_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          btn_db_reg <= sync2_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      score_reg    <= '0;
      best_reg     <= '0;
      hold_cnt_reg <= '0;
      pending_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          pending_reg <= 1'b0;
          if (press) begin
            state_reg <= ST_PLAY;
            score_reg <= '0;
          end
        end
        ST_PLAY: begin
          if (bird_dead) begin
            state_reg    <= ST_DEAD;
            hold_cnt_reg <= '0;
            pending_reg  <= 1'b0;
            if (score_reg > best_reg) begin
              best_reg <= score_reg;
            end
          end else begin
            if (pipe_passed && (score_reg != SCORE_MAX)) begin
              score_reg <= score_reg + 1'b1;
            end
            // A fresh press re-arms the flap even on the tick that fires the old one.
            if (press) begin
              pending_reg <= 1'b1;
            end else if (tick) begin
              pending_reg <= 1'b0;
            end
          end
        end
        ST_DEAD: begin
          pending_reg <= 1'b0;
          if (press && (hold_cnt_reg == HOLD_MAX)) begin
            state_reg <= ST_IDLE;
          end else if (tick && (hold_cnt_reg != HOLD_MAX)) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg   <= ST_IDLE;
          pending_reg <= 1'b0;
        end
      endcase
    end
  end

  assign state    = state_reg;
  assign tick_ms  = tick;
  assign up_pulse = (state_reg == ST_PLAY) && pending_reg && tick;
  assign bird_rst = (state_reg == ST_IDLE);
  assign score    = score_reg;
  assign best     = best_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short timing parameters
// (4 clk per tick, 2-tick debounce, 3-tick dead hold).
module tb_game_flow_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       bird_dead = 1'b0;
  logic       pipe_passed = 1'b0;
  logic [1:0] state;
  logic       tick_ms;
  logic       up_pulse;
  logic       bird_rst;
  logic [9:0] score;
  logic [9:0] best;

  int n_checks = 0;
  int n_fail = 0;
  int up_cnt = 0;
  int up_stray = 0;
  int up_base;

  always #5 clk = ~clk;

  game_flow_ctrl #(
    .MS_DIV(4),
    .DEBOUNCE_MS(2),
    .DEAD_HOLD_MS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .bird_dead(bird_dead),
    .pipe_passed(pipe_passed),
    .state(state),
    .tick_ms(tick_ms),
    .up_pulse(up_pulse),
    .bird_rst(bird_rst),
    .score(score),
    .best(best)
  );

  // Counts flap strobes and any that land off a tick.
  always @(negedge clk) begin
    if (up_pulse === 1'b1) begin
      up_cnt++;
      if (tick_ms !== 1'b1) up_stray++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_tick();
    int g = 0;
    while (tick_ms !== 1'b1 && g < 8) begin
      step();
      g++;
    end
    check_val("wait_tick", 32'(tick_ms), 1);
  endtask

  // Long enough high to cover three ticks, then long enough low to debounce the release.
  task automatic press_btn();
    btn_raw = 1'b1;
    repeat (12) step();
    btn_raw = 1'b0;
    repeat (16) step();
  endtask

  task automatic pipe();
    pipe_passed = 1'b1;
    step();
    pipe_passed = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_state", 32'(state), 0);
    check_val("rst_bird_rst", 32'(bird_rst), 1);
    check_val("rst_tick", 32'(tick_ms), 0);
    check_val("rst_up", 32'(up_pulse), 0);
    check_val("rst_score", 32'(score), 0);
    check_val("rst_best", 32'(best), 0);

    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      check_val($sformatf("tick_c%0d", k), 32'(tick_ms), (k % 4 == 0) ? 1 : 0);
      step();
    end
    check_val("tick_state", 32'(state), 0);
    check_val("tick_bird_rst", 32'(bird_rst), 1);

    // Glitch lasting one tick sample must not start a game.
    btn_raw = 1'b1;
    repeat (4) step();
    btn_raw = 1'b0;
    repeat (12) step();
    check_val("glitch_state", 32'(state), 0);

    up_base = up_cnt;
    press_btn();
    check_val("start_state", 32'(state), 1);
    check_val("start_score", 32'(score), 0);
    check_val("start_bird_rst", 32'(bird_rst), 0);
    check_val("start_no_flap", 32'(up_cnt - up_base), 0);

    press_btn();
    check_val("flap1", 32'(up_cnt - up_base), 1);
    press_btn();
    check_val("flap2", 32'(up_cnt - up_base), 2);
    check_val("flap_on_tick", 32'(up_stray), 0);

    repeat (5) pipe();
    check_val("score5", 32'(score), 5);

    // Die on a tick with a simultaneous pipe; button rises so its press lands at hold 1.
    wait_tick();
    up_base = up_cnt;
    bird_dead = 1'b1;
    pipe_passed = 1'b1;
    btn_raw = 1'b1;
    step();
    bird_dead = 1'b0;
    pipe_passed = 1'b0;
    check_val("dead_state", 32'(state), 2);
    check_val("dead_score", 32'(score), 5);
    check_val("dead_best", 32'(best), 5);
    check_val("dead_bird_rst", 32'(bird_rst), 0);
    repeat (9) step();
    btn_raw = 1'b0;
    repeat (16) step();
    check_val("hold_early_press", 32'(state), 2);
    check_val("dead_no_flap", 32'(up_cnt - up_base), 0);

    press_btn();
    check_val("hold_done_state", 32'(state), 0);
    check_val("hold_done_bird_rst", 32'(bird_rst), 1);
    check_val("idle_score_kept", 32'(score), 5);

    press_btn();
    check_val("g2_state", 32'(state), 1);
    check_val("g2_score_clr", 32'(score), 0);
    repeat (3) pipe();
    bird_dead = 1'b1;
    step();
    bird_dead = 1'b0;
    step();
    check_val("g2_dead", 32'(state), 2);
    check_val("g2_score", 32'(score), 3);
    check_val("g2_best", 32'(best), 5);
    pipe();
    check_val("dead_pipe_ignored", 32'(score), 3);

    repeat (16) step();
    press_btn();
    check_val("g3_idle", 32'(state), 0);
    pipe();
    check_val("idle_pipe_ignored", 32'(score), 3);
    press_btn();
    check_val("g3_play", 32'(state), 1);
    repeat (1002) pipe();
    check_val("score_sat", 32'(score), 999);
    bird_dead = 1'b1;
    step();
    bird_dead = 1'b0;
    step();
    check_val("best_999", 32'(best), 999);

    repeat (16) step();
    press_btn();
    press_btn();
    check_val("g4_play", 32'(state), 1);
    repeat (7) pipe();
    check_val("g4_score7", 32'(score), 7);

    // Asynchronous reset mid-game, checked before any clock edge.
    btn_raw = 1'b1;
    rst_n = 1'b0;
    #1;
    check_val("arst_state", 32'(state), 0);
    check_val("arst_score", 32'(score), 0);
    check_val("arst_best", 32'(best), 0);
    check_val("arst_bird_rst", 32'(bird_rst), 1);
    check_val("arst_tick", 32'(tick_ms), 0);
    check_val("arst_up", 32'(up_pulse), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check_val($sformatf("rst_hold_up%0d", k), 32'(up_pulse), 0);
    end
    btn_raw = 1'b0;
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_val($sformatf("resume_tick%0d", k), 32'(tick_ms), (k == 4) ? 1 : 0);
      step();
    end
    check_val("resume_state", 32'(state), 0);
    check_val("final_flap_on_tick", 32'(up_stray), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 SHALL have parameter MS_DIV, default 100000, meaning clk cycles per 1 ms tick (100 MHz clk).
REQ-002 SHALL have parameter DEBOUNCE_MS, default 10, meaning ms ticks a button level must stay stable before it is accepted.
REQ-003 SHALL have parameter DEAD_HOLD_MS, default 1000, meaning ms ticks in DEAD before a press is honoured.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  1  unsynchronised up button.
- bird_dead  in  1  collision level from bird datapath.
- pipe_passed  in  1  one-clk pulse per pipe cleared.
- state  out  2  0 IDLE, 1 PLAY, 2 DEAD.
- tick_ms  out  1  one-clk strobe every MS_DIV cycles.
- up_pulse  out  1  one-clk flap strobe.
- bird_rst  out  1  re-initialise bird position/velocity.
- score  out  10  current score, binary.
- best  out  10  best score since reset, binary.

Function
REQ-005 SHALL run a prescaler counting 0..MS_DIV-1 and wrapping to 0; tick_ms is high exactly in the cycle the count equals MS_DIV-1.
REQ-006 SHALL synchronise btn_raw through two flops before any other use.
REQ-007 SHALL update the debounced level btn_db only after the synchronised level has differed from btn_db on DEBOUNCE_MS consecutive tick_ms samples.
- Any sample equal to btn_db restarts the count.
REQ-008 SHALL define a press event as a 0->1 transition of btn_db; a release generates no event.
REQ-009 SHALL implement a 3-state FSM with encoded value on the state output:
- IDLE(0) -> PLAY(1) on a press event; this press is consumed and generates no up_pulse.
- PLAY -> DEAD(2) in the cycle after bird_dead is sampled high.
- DEAD -> IDLE on a press event once the hold counter has reached DEAD_HOLD_MS ticks; presses before then are discarded.
- Illegal value 3 -> IDLE on the next clk.
REQ-010 SHALL, in PLAY, latch each press event as a pending flap and assert up_pulse for one clk coincident with the next tick_ms, then clear the pending flag.
- Multiple presses between ticks yield one up_pulse.
- A pending flap is discarded on leaving PLAY.
REQ-011 SHALL hold bird_rst high whenever state is IDLE and low otherwise.
REQ-012 SHALL clear the DEAD hold counter on entry to DEAD, increment it per tick_ms, and saturate it at DEAD_HOLD_MS.
REQ-013 SHALL clear score to 0 on the IDLE->PLAY transition.
- Score increments by 1 per pipe_passed in PLAY only.
- Score saturates at 999.
REQ-014 SHALL, on the PLAY->DEAD transition, load best with score if score > best.
REQ-015 SHALL give bird_dead precedence when bird_dead and pipe_passed occur in the same PLAY cycle: transition to DEAD, no score increment.
REQ-016 SHALL ignore pipe_passed and bird_dead in IDLE and DEAD.
- Score holds its final value through DEAD and IDLE until the next game starts.

Reset
REQ-017 SHALL, while rst_n is low, immediately force:
- state=0, bird_rst=1, tick_ms=0, up_pulse=0, score=0, best=0.
- prescaler, debounce counter, hold counter, sync flops, btn_db and pending flag to 0.
REQ-018 SHALL apply REQ-017 on assertion at any time, including mid-game, and resume from IDLE with the prescaler at 0 on the first clk edge after rst_n rises.

Verification (MS_DIV=4, DEBOUNCE_MS=2, DEAD_HOLD_MS=3)
REQ-019 SHALL cover tick timing: release reset, run 20 clks -> tick_ms high on clks 4, 8, 12, 16, 20 only; state=0, bird_rst=1.
REQ-020 SHALL cover debounce:
- btn_raw high for 1 tick then low -> no press event.
- btn_raw held high for 3 ticks -> state goes 0->1, no up_pulse, score=0.
REQ-021 SHALL cover flapping: in PLAY, two presses (each debounced) separated by release -> exactly one up_pulse per press, each coincident with tick_ms.
REQ-022 SHALL cover scoring and best:
- 5 pipe_passed pulses, then bird_dead with a simultaneous pipe_passed -> score=5, state=2, best=5.
- Next game with 3 passes then death -> best stays 5.
REQ-023 SHALL cover the DEAD hold: press at hold tick 1 -> ignored; press after 3 ticks -> state=0, bird_rst=1.
REQ-024 SHALL cover reset mid-game: rst_n low in PLAY with score=7 -> state=0, score=0, best=0 asynchronously; up_pulse never asserts during reset.
